l_next_wb_buffer: RTL and testbench
===================================

# l_next_wb_buffer

Write-back buffer between the L1 instruction/data caches and the next-level memory stub. It accepts evicted dirty 512-bit lines from a cache, holds up to DEPTH of them in FIFO order, and drains them to the next level over a valid/ready write channel. It also answers same-cycle miss lookups, so a cache refill never reads stale next-level data for a line still waiting to be written back. A write to a line already queued, other than the head entry, is coalesced in place.

## Interface
Parameters:
- DEPTH, 4, number of line entries; power of two, ≥2
- ADDR_W, 26, line address width (byte address [31:6])
- LINE_W, 512, line width in bits

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wb_valid  in  1  cache presents an evicted line
- wb_ready  out  1  buffer can accept or coalesce wb_addr this cycle
- wb_addr  in  ADDR_W  line address of the evicted line
- wb_data  in  LINE_W  evicted line data
- mem_valid  out  1  head entry presented to the next level
- mem_ready  in  1  next level accepts the head entry
- mem_addr  out  ADDR_W  head entry address
- mem_data  out  LINE_W  head entry data
- lk_addr  in  ADDR_W  refill lookup address from the miss handler
- lk_hit  out  1  lk_addr matches a valid entry
- lk_data  out  LINE_W  data of the youngest matching entry; 0 when lk_hit=0
- count  out  $clog2(DEPTH)+1  number of valid entries
- full  out  1  count==DEPTH
- empty  out  1  count==0

## Operation
- Storage: DEPTH entries of {valid, addr, data}, organised as a circular FIFO. head_ptr and tail_ptr are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- Coalesce match (cm): a valid entry other than the head has addr==wb_addr. Coalescing excludes the head because the head may be mid-handshake.
- wb_ready = !full || cm.
- Accept happens when wb_valid && wb_ready:
  - If cm: overwrite that entry's data. count, tail_ptr and FIFO order are unchanged.
  - Else: write {1, wb_addr, wb_data} at tail_ptr, then tail_ptr+1 and count+1.
- A write that matches only the head is appended as a new entry. Two entries may then share an address.
- Drain:
  - mem_valid = !empty. mem_addr and mem_data come from the head entry, or are 0 when empty.
  - When mem_valid && mem_ready: clear the head valid bit, then head_ptr+1 and count-1.
- Simultaneous append and drain: count is unchanged and both pointers advance.
- Simultaneous coalesce and drain: count-1. Coalescing never targets the head, so there is no conflict.
- Full with mem_ready=1 and a non-matching write: wb_ready=0 that cycle, with no bypass. The write is accepted the next cycle.
- Lookup:
  - Combinational over the registered state at the start of the cycle.
  - It includes the head entry even when that entry drains this cycle. It excludes data written this cycle.
  - If more than one entry matches, the one closest to the tail (youngest) wins.
- Arithmetic: count is updated as count + enq - deq using unsigned arithmetic. It never exceeds DEPTH and never underflows.

## Timing
- Reset (asynchronous assert, synchronous deassert at the clk edge):
  - head_ptr=0, tail_ptr=0, count=0, all valid bits 0.
  - Output values during and after reset: mem_valid=0, mem_addr=0, mem_data=0, wb_ready=1, lk_hit=0, lk_data=0, empty=1, full=0.
  - Data storage need not be reset.
- Reset asserted mid-handshake drops all queued lines immediately, with no drain.
- Write-to-drain latency: a line accepted at edge N gives mem_valid=1 in cycle N+1 if the buffer was empty.
- Write-to-lookup latency: a line accepted at edge N hits on lookups from cycle N+1.
- Handshake: once mem_valid=1, mem_addr and mem_data stay stable until the cycle in which mem_ready=1.
- mem_ready while empty is ignored.
- wb_ready and lk_hit are combinational from inputs and state; there is no registered-output stage.
- Throughput: one accept and one drain per cycle sustained.

## Test plan
- Reset, then write A=0x0000123 with data D1, mem_ready=0 → cycle+1: mem_valid=1, mem_addr=0x0000123, mem_data=D1, count=1, and lk_addr=0x0000123 gives lk_hit=1, lk_data=D1.
- Fill 4 distinct lines with mem_ready=0 → full=1 and wb_ready=0 for new address 0x5; hold the write and assert mem_ready → 0x5 is accepted the cycle after the drain, and order is preserved on mem_*.
- Queue 0x10 (head) then 0x20 with D2, then write 0x20 with D3 → count stays 2, and draining yields 0x10 then 0x20 with D3. Writing 0x10 again while it is the head → appended, count=3, and lookup of 0x10 returns the new data.
- Continuous write and drain for 10 lines with mem_ready=1 → count stays 1 in steady state, pointers wrap past DEPTH-1, and lines emerge in order without gaps.
- Stall mem_ready=0 for 5 cycles with mem_valid=1 → mem_addr and mem_data are unchanged across all 5 cycles.
- Assert rst_n=0 asynchronously with 3 entries queued, mid-cycle → mem_valid=0, count=0, empty=1 immediately, and a subsequent lookup of any queued address gives lk_hit=0.

Source files
------------

// File: rtl/l_next_wb_buffer.sv
// l_next_wb_buffer: write-back buffer between L1 caches and next-level memory.
// Holds up to DEPTH evicted lines in FIFO order and drains them over a
// valid/ready channel. A write to a queued line other than the head is
// merged into that entry. It also answers same-cycle refill lookups.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   wb_valid/wb_ready/wb_addr/wb_data   eviction input channel
//   mem_valid/mem_ready/mem_addr/mem_data  drain channel to next level
//   lk_addr -> lk_hit/lk_data   combinational lookup (youngest match wins)
//   count/full/empty            occupancy status
module l_next_wb_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 26,
    parameter int unsigned LINE_W = 512
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wb_valid,
    output logic                     wb_ready,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [LINE_W-1:0]        wb_data,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [LINE_W-1:0]        mem_data,
    input  logic [ADDR_W-1:0]        lk_addr,
    output logic                     lk_hit,
    output logic [LINE_W-1:0]        lk_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]   r_valid;
    logic [ADDR_W-1:0]  r_addr [DEPTH];
    logic [LINE_W-1:0]  r_data [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;

    logic               w_cm;
    logic [PTR_W-1:0]   w_cm_idx;
    logic [PTR_W-1:0]   w_idx;
    logic               w_lk_hit;
    logic [LINE_W-1:0]  w_lk_data;
    logic               w_enq;
    logic               w_coal;
    logic               w_deq;

    // Status flags
    assign count = r_count;
    assign empty = (r_count == '0);
    assign full  = (r_count == CNT_W'(DEPTH));

    // Coalesce match and lookup, scanned oldest to youngest so the youngest match wins
    always_comb begin
        w_cm      = 1'b0;
        w_cm_idx  = '0;
        w_idx     = '0;
        w_lk_hit  = 1'b0;
        w_lk_data = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            w_idx = r_head + PTR_W'(k);
            // k==0 is the head, which may be mid-handshake and is never merged into
            if (k != 0 && r_valid[w_idx] && (r_addr[w_idx] == wb_addr)) begin
                w_cm     = 1'b1;
                w_cm_idx = w_idx;
            end
            if (r_valid[w_idx] && (r_addr[w_idx] == lk_addr)) begin
                w_lk_hit  = 1'b1;
                w_lk_data = r_data[w_idx];
            end
        end
    end

    assign lk_hit  = w_lk_hit;
    assign lk_data = w_lk_data;

    // Handshakes
    assign wb_ready  = !full || w_cm;
    assign mem_valid = !empty;
    assign mem_addr  = empty ? '0 : r_addr[r_head];
    assign mem_data  = empty ? '0 : r_data[r_head];

    assign w_coal = wb_valid && wb_ready && w_cm;
    assign w_enq  = wb_valid && wb_ready && !w_cm;
    assign w_deq  = mem_valid && mem_ready;

    // Control state: pointers, occupancy and valid bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_deq) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end
            if (w_enq) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
        end
    end

    // Line storage; contents are qualified by r_valid so no reset is needed
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr[r_tail] <= wb_addr;
            r_data[r_tail] <= wb_data;
        end else if (w_coal) begin
            r_data[w_cm_idx] <= wb_data;
        end
    end

endmodule

// File: tb/tb_l_next_wb_buffer.sv
// Testbench for l_next_wb_buffer: directed scenarios then random traffic,
// all checked against a queue-based reference model.
module tb_l_next_wb_buffer;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 26;
    localparam int unsigned LINE_W = 512;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

    logic               clk;
    logic               rst_n;
    logic               wb_valid;
    logic               wb_ready;
    logic [ADDR_W-1:0]  wb_addr;
    logic [LINE_W-1:0]  wb_data;
    logic               mem_valid;
    logic               mem_ready;
    logic [ADDR_W-1:0]  mem_addr;
    logic [LINE_W-1:0]  mem_data;
    logic [ADDR_W-1:0]  lk_addr;
    logic               lk_hit;
    logic [LINE_W-1:0]  lk_data;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               empty;

    l_next_wb_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .lk_addr   (lk_addr),
        .lk_hit    (lk_hit),
        .lk_data   (lk_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] data;
    } ent_t;

    ent_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic [LINE_W-1:0] d1, d2, d3, d4;

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] rnd_line();
        logic [LINE_W-1:0] r;
        r = '0;
        for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // One clock cycle: check outputs at the negedge against the model, then apply the edge
    task automatic step();
        int                j;
        logic              cm;
        logic              rdy;
        logic              hit;
        logic [LINE_W-1:0] ld;
        ent_t              h;
        @(negedge clk);
        j = -1;
        for (int k = 1; k < q.size(); k++) if (q[k].addr == wb_addr) j = k;
        cm  = (j >= 0);
        rdy = (q.size() < DEPTH) || cm;
        hit = 1'b0;
        ld  = '0;
        for (int k = 0; k < q.size(); k++) begin
            if (q[k].addr == lk_addr) begin
                hit = 1'b1;
                ld  = q[k].data;
            end
        end
        h = (q.size() > 0) ? q[0] : '0;
        chk("wb_ready",  LINE_W'(wb_ready),  LINE_W'(rdy));
        chk("mem_valid", LINE_W'(mem_valid), LINE_W'(q.size() > 0));
        chk("mem_addr",  LINE_W'(mem_addr),  LINE_W'(h.addr));
        chk("mem_data",  mem_data,           h.data);
        chk("lk_hit",    LINE_W'(lk_hit),    LINE_W'(hit));
        chk("lk_data",   lk_data,            ld);
        chk("count",     LINE_W'(count),     LINE_W'(q.size()));
        chk("full",      LINE_W'(full),      LINE_W'(q.size() == DEPTH));
        chk("empty",     LINE_W'(empty),     LINE_W'(q.size() == 0));
        @(posedge clk);
        if (rst_n) begin
            if (wb_valid && rdy && cm) q[j].data = wb_data;
            if (q.size() > 0 && mem_ready) void'(q.pop_front());
            if (wb_valid && rdy && !cm) q.push_back('{addr: wb_addr, data: wb_data});
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d, input logic mr);
        wb_valid  = v;
        wb_addr   = a;
        wb_data   = d;
        mem_ready = mr;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        lk_addr = '0;
        d1 = rnd_line(); d2 = rnd_line(); d3 = rnd_line(); d4 = rnd_line();

        // Values held during reset
        #12;
        chk("rst_mem_valid", LINE_W'(mem_valid), '0);
        chk("rst_mem_data",  mem_data,           '0);
        chk("rst_wb_ready",  LINE_W'(wb_ready),  LINE_W'(1));
        chk("rst_lk_hit",    LINE_W'(lk_hit),    '0);
        chk("rst_empty",     LINE_W'(empty),     LINE_W'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();

        // Single write then head and lookup visible next cycle
        drive(1'b1, 26'h0000123, d1, 1'b0);
        lk_addr = 26'h0000123;
        step();
        drive(1'b0, '0, '0, 1'b0);
        step();
        chk("first_mem_addr", LINE_W'(mem_addr), LINE_W'(26'h0000123));
        chk("first_lk_data",  lk_data,           d1);
        drive(1'b0, '0, '0, 1'b1);
        step();

        // Fill, stall a non-matching write while full, then drain one
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, ADDR_W'(i), rnd_line(), 1'b0);
            lk_addr = ADDR_W'(i - 1);
            step();
        end
        drive(1'b1, 26'h5, d2, 1'b0);
        step();
        drive(1'b1, 26'h5, d2, 1'b1);
        step();
        drive(1'b1, 26'h5, d2, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b1);
        lk_addr = 26'h5;
        for (int i = 0; i < 5; i++) step();

        // Coalesce into a non-head entry; a head match appends instead
        drive(1'b1, 26'h10, d1, 1'b0); step();
        drive(1'b1, 26'h20, d2, 1'b0); step();
        drive(1'b1, 26'h20, d3, 1'b0); step();
        drive(1'b0, '0, '0, 1'b0);
        lk_addr = 26'h20;
        step();
        chk("coal_count", LINE_W'(count),  LINE_W'(2));
        chk("coal_data",  lk_data,         d3);
        drive(1'b1, 26'h10, d4, 1'b0); step();
        drive(1'b0, '0, '0, 1'b0);
        lk_addr = 26'h10;
        step();
        chk("headapp_count", LINE_W'(count), LINE_W'(3));
        chk("headapp_lk",    lk_data,        d4);
        drive(1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 4; i++) step();

        // Streaming: write and drain every cycle, pointers wrap
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, ADDR_W'(32'h100 + i), rnd_line(), 1'b1);
            lk_addr = ADDR_W'(32'h100 + i - 1);
            step();
        end
        drive(1'b0, '0, '0, 1'b1);
        step();

        // Stall with data present: head must hold
        drive(1'b1, 26'h33, d1, 1'b0); step();
        drive(1'b1, 26'h34, d2, 1'b0); step();
        drive(1'b1, 26'h35, d3, 1'b0); step();
        drive(1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 5; i++) step();

        // Async reset mid-cycle with 3 entries queued
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_mem_valid", LINE_W'(mem_valid), '0);
        chk("arst_count",     LINE_W'(count),     '0);
        chk("arst_empty",     LINE_W'(empty),     LINE_W'(1));
        lk_addr = 26'h34;
        #1;
        chk("arst_lk_hit",  LINE_W'(lk_hit), '0);
        chk("arst_lk_data", lk_data,         '0);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();

        // Random traffic over a small address pool to exercise merges and duplicates
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 2) != 0), ADDR_W'($urandom_range(0, 6)), rnd_line(),
                  1'($urandom_range(0, 2) == 0));
            lk_addr = ADDR_W'($urandom_range(0, 6));
            step();
        end
        drive(1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 6; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
